// File: rtl/f_div_issuer.sv
// f_div_issuer: elastic valid/ready front end for the f_div divider. It issues one operation at a
// time and queues {result, error} in a small FIFO. Optional watchdog: define F_DIV_ISSUER_TIMEOUT_EN.
module f_div_issuer #(
  parameter int FLEN    = 64,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arg_vld,
  output logic            arg_rdy,
  input  logic [FLEN-1:0] arg_a,
  input  logic [FLEN-1:0] arg_b,
  output logic [FLEN-1:0] div_a,
  output logic [FLEN-1:0] div_b,
  output logic            div_up_valid,
  input  logic [FLEN-1:0] div_res,
  input  logic            div_down_valid,
  input  logic            div_busy,
  input  logic            div_error,
  output logic            res_vld,
  input  logic            res_rdy,
  output logic [FLEN-1:0] res,
  output logic            res_err,
  output logic            timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [FLEN-1:0] mem_res [DEPTH];
  logic [DEPTH-1:0] mem_err;
  logic            accept, push, pop, expire, in_flight;
  logic [FLEN-1:0] push_res;
  logic            push_err;

  // Admission requires a free slot, so the single in-flight result can always be pushed.
  assign arg_rdy      = (state == IDLE) && (count < DEPTH_C) && !div_busy;
  assign accept       = arg_vld && arg_rdy;
  assign in_flight    = (state == ISSUE) || (state == WAIT);
  assign push         = (in_flight && div_down_valid) || expire;
  assign res_vld      = (count != '0);
  assign pop          = res_vld && res_rdy;
  assign div_up_valid = (state == ISSUE);
  assign res          = res_vld ? mem_res[rd_ptr] : '0;
  assign res_err      = res_vld & mem_err[rd_ptr];

`ifdef F_DIV_ISSUER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [FLEN-1:0] QNAN =
    (FLEN == 32) ? FLEN'(32'h7FC0_0000) : FLEN'(64'h7FF8_0000_0000_0000);

  logic [WW-1:0] wd_cnt;

  assign expire   = (state == WAIT) && !div_down_valid && (wd_cnt == WD_LAST);
  assign push_res = expire ? QNAN : div_res;
  assign push_err = expire | div_error;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state != WAIT)       wd_cnt <= '0;
      else if (!div_down_valid) wd_cnt <= wd_cnt + 1'b1;
      if (expire) timeout <= 1'b1;
    end
  end
`else
  assign expire   = 1'b0;
  assign push_res = div_res;
  assign push_err = div_error;
  assign timeout  = 1'b0;
`endif

  // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: state_nxt gets its default first, so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = div_down_valid ? IDLE : WAIT;
      WAIT:    if (div_down_valid || expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands only change on acceptance, so they stay stable for the whole divide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_a <= '0;
      div_b <= '0;
    end else if (accept) begin
      div_a <= arg_a;
      div_b <= arg_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; res/res_err are masked by res_vld instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_res[wr_ptr] <= push_res;
      mem_err[wr_ptr] <= push_err;
    end
  end

endmodule

// File: tb/tb_f_div_issuer.sv
// Directed bench for f_div_issuer with a fixed-latency behavioural divider plus manual overrides.
`timescale 1ns/1ps
module tb_f_div_issuer;

  localparam int FLEN  = 64;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;
`ifdef F_DIV_ISSUER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic arg_vld = 1'b0, arg_rdy;
  logic [63:0] arg_a = '0, arg_b = '0;
  logic [63:0] div_a, div_b, div_res, res;
  logic div_up_valid, div_down_valid, div_busy, div_error;
  logic res_vld, res_rdy = 1'b0, res_err, timeout;

  // divider model and manual overrides
  logic model_en = 1'b1;
  logic m_dv = 1'b0, m_busy = 1'b0, m_err = 1'b0;
  logic [63:0] m_res = '0, m_a = '0, m_b = '0;
  int m_cnt = 0;
  logic man_dv = 1'b0, man_busy = 1'b0, man_err = 1'b0;
  logic [63:0] man_res = '0;

  int n_checks = 0, n_err = 0;
  int got, k, pulses;
  logic stable, prev_dv;
  logic [63:0] got_v [5];
  logic [63:0] bp_a [5];
  logic [63:0] bp_exp [5];

  always #5 clk = ~clk;

  assign div_down_valid = m_dv | man_dv;
  assign div_res        = man_dv ? man_res : m_res;
  assign div_error      = man_dv ? man_err : m_err;
  assign div_busy       = m_busy | man_busy;

  f_div_issuer #(.FLEN(FLEN), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .arg_vld(arg_vld), .arg_rdy(arg_rdy), .arg_a(arg_a), .arg_b(arg_b),
    .div_a(div_a), .div_b(div_b), .div_up_valid(div_up_valid),
    .div_res(div_res), .div_down_valid(div_down_valid), .div_busy(div_busy), .div_error(div_error),
    .res_vld(res_vld), .res_rdy(res_rdy), .res(res), .res_err(res_err), .timeout(timeout)
  );

  always @(posedge clk) begin
    m_dv <= 1'b0;
    if (model_en && div_up_valid) begin
      m_a    <= div_a;
      m_b    <= div_b;
      m_cnt  <= LAT;
      m_busy <= 1'b1;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_dv   <= 1'b1;
        m_busy <= 1'b0;
        m_err  <= (m_b == 64'd0);
        m_res  <= (m_b == 64'd0) ? 64'h7FF0_0000_0000_0000
                                 : $realtobits($bitstoreal(m_a) / $bitstoreal(m_b));
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge following acceptance (DUT in ISSUE).
  task automatic send(input logic [63:0] a, input logic [63:0] b, input string tag);
    int w;
    w = 0;
    arg_a = a; arg_b = b; arg_vld = 1'b1;
    #1;
    while (!arg_rdy && w < 300) begin
      @(negedge clk); #1; w++;
    end
    check({tag, "_accept"}, arg_rdy, 1'b1);
    @(negedge clk);
    arg_vld = 1'b0;
  endtask

  task automatic get_res(input logic [63:0] exp, input logic exp_err, input string tag);
    int w;
    w = 0;
    while (!res_vld && w < 300) begin
      @(negedge clk); w++;
    end
    check({tag, "_res"}, res, exp);
    check({tag, "_err"}, res_err, exp_err);
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bp_a   = '{64'h4010_0000_0000_0000, 64'h4020_0000_0000_0000, 64'h4030_0000_0000_0000,
               64'h4040_0000_0000_0000, 64'h4050_0000_0000_0000};
    bp_exp = '{64'h4000_0000_0000_0000, 64'h4010_0000_0000_0000, 64'h4020_0000_0000_0000,
               64'h4030_0000_0000_0000, 64'h4040_0000_0000_0000};

    // reset
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_res_vld", res_vld, 1'b0);
    check("rst_arg_rdy", arg_rdy, 1'b1);
    check("rst_up_valid", div_up_valid, 1'b0);
    check("rst_div_a", div_a, 64'd0);
    check("rst_div_b", div_b, 64'd0);
    check("rst_res", res, 64'd0);
    check("rst_res_err", res_err, 1'b0);
    check("rst_timeout", timeout, 1'b0);

    // divider busy blocks intake
    man_busy = 1'b1;
    #1 check("busy_blocks", arg_rdy, 1'b0);
    man_busy = 1'b0;
    @(negedge clk);

    // 6.0 / 2.0
    send(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, "t1");
    check("t1_up_valid", div_up_valid, 1'b1);
    check("t1_div_a", div_a, 64'h4018_0000_0000_0000);
    check("t1_div_b", div_b, 64'h4000_0000_0000_0000);
    pulses = 0; stable = 1'b1; prev_dv = 1'b0; k = 0;
    while (!res_vld && k < 50) begin
      prev_dv = div_down_valid;
      @(negedge clk); k++;
      if (div_up_valid) pulses++;
      if (div_a !== 64'h4018_0000_0000_0000 || div_b !== 64'h4000_0000_0000_0000) stable = 1'b0;
    end
    check("t1_extra_pulses", pulses, 0);
    check("t1_operands_stable", stable, 1'b1);
    check("t1_latency", prev_dv, 1'b1);
    get_res(64'h4008_0000_0000_0000, 1'b0, "t1");

    // 1.0 / 0.0
    send(64'h3FF0_0000_0000_0000, 64'd0, "t2");
    get_res(64'h7FF0_0000_0000_0000, 1'b1, "t2");

    // back-pressure: four fill the FIFO, the fifth stalls until drain
    res_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(bp_a[i], 64'h4000_0000_0000_0000, $sformatf("t3_req%0d", i));
    repeat (8) @(negedge clk);
    check("t3_full_vld", res_vld, 1'b1);
    arg_a = bp_a[4]; arg_b = 64'h4000_0000_0000_0000; arg_vld = 1'b1;
    #1 check("t3_stall", arg_rdy, 1'b0);
    repeat (4) @(negedge clk);
    #1 check("t3_stall_hold", arg_rdy, 1'b0);
    got = 0;
    fork
      send(bp_a[4], 64'h4000_0000_0000_0000, "t3_req4");
      begin
        int w;
        w = 0;
        res_rdy = 1'b1;
        while (got < 5 && w < 400) begin
          if (res_vld) begin
            got_v[got] = res;
            got++;
          end
          @(negedge clk); w++;
        end
        res_rdy = 1'b0;
      end
    join
    check("t3_count", got, 5);
    for (int i = 0; i < 5; i++) check($sformatf("t3_order%0d", i), got_v[i], bp_exp[i]);
    #1 check("t3_empty", res_vld, 1'b0);
    @(negedge clk);

    // result arriving in the ISSUE cycle
    model_en = 1'b0;
    send(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, "t4");
    man_dv = 1'b1; man_res = 64'hCAFE_F00D_1234_5678; man_err = 1'b0;
    @(negedge clk);
    man_dv = 1'b0;
    #1;
    check("t4_vld", res_vld, 1'b1);
    check("t4_res", res, 64'hCAFE_F00D_1234_5678);
    check("t4_up_valid", div_up_valid, 1'b0);
    check("t4_arg_rdy", arg_rdy, 1'b1);
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
    #1 check("t4_empty", res_vld, 1'b0);

    // simultaneous push and pop with count = DEPTH-1
    model_en = 1'b1;
    send(64'h3FF0_0000_0000_0000, 64'h3FE0_0000_0000_0000, "t5_req0");
    send(64'h4000_0000_0000_0000, 64'h3FE0_0000_0000_0000, "t5_req1");
    send(64'h4010_0000_0000_0000, 64'h3FE0_0000_0000_0000, "t5_req2");
    repeat (8) @(negedge clk);
    model_en = 1'b0;
    send(64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, "t5_req3");
    repeat (2) @(negedge clk);
    check("t5_head_before", res, 64'h4000_0000_0000_0000);
    man_dv = 1'b1; man_res = 64'h0123_4567_89AB_CDEF; man_err = 1'b1; res_rdy = 1'b1;
    @(negedge clk);
    man_dv = 1'b0; res_rdy = 1'b0;
    #1 check("t5_head_after", res, 64'h4010_0000_0000_0000);
    get_res(64'h4010_0000_0000_0000, 1'b0, "t5_e1");
    get_res(64'h4020_0000_0000_0000, 1'b0, "t5_e2");
    get_res(64'h0123_4567_89AB_CDEF, 1'b1, "t5_e3");
    #1 check("t5_empty", res_vld, 1'b0);
    @(negedge clk);

    // reset mid-WAIT, then a stale result
    send(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, "t6");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    man_dv = 1'b1; man_res = 64'hDEAD_BEEF_DEAD_BEEF; man_err = 1'b1;
    @(negedge clk);
    man_dv = 1'b0;
    #1;
    check("t6_vld", res_vld, 1'b0);
    check("t6_arg_rdy", arg_rdy, 1'b1);
    check("t6_div_a", div_a, 64'd0);
    repeat (2) @(negedge clk);
    check("t6_vld_later", res_vld, 1'b0);

    // watchdog
    send(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, "t7");
`ifdef F_DIV_ISSUER_TIMEOUT_EN
    k = 0;
    while (!res_vld && k < 100) begin
      @(negedge clk); k++;
    end
    check("t7_cycles", k, 17);
    check("t7_res", res, 64'h7FF8_0000_0000_0000);
    check("t7_err", res_err, 1'b1);
    check("t7_timeout", timeout, 1'b1);
    man_dv = 1'b1; man_res = 64'h4008_0000_0000_0000; man_err = 1'b0;
    @(negedge clk);
    man_dv = 1'b0; res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
    #1;
    check("t7_late_ignored", res_vld, 1'b0);
    check("t7_timeout_sticky", timeout, 1'b1);
`else
    repeat (40) @(negedge clk);
    check("t7_no_timeout", timeout, 1'b0);
    check("t7_still_waiting", res_vld, 1'b0);
    check("t7_rdy_low", arg_rdy, 1'b0);
    man_dv = 1'b1; man_res = 64'h4008_0000_0000_0000; man_err = 1'b0;
    @(negedge clk);
    man_dv = 1'b0;
    get_res(64'h4008_0000_0000_0000, 1'b0, "t7_late");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/f_div_issuer.md
Name: f_div_issuer

Overview:
- Upstream-side driver for the `f_div` floating-point divider wrapper.
- Accepts divide requests on a valid/ready interface and issues them to the divider as a single-cycle `up_valid` pulse.
- Holds the operands stable until `down_valid` returns, then buffers result plus error flag in a small FIFO.
- Sits between the arithmetic-block scheduler and the divider; presents divide as an elastic valid/ready stage.

Parameters:
- FLEN, 64, operand/result width; must match the divider.
- DEPTH, 4, result FIFO entries; power of two, minimum 2.
- TIMEOUT, 256, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset (0 = reset asserted).
- arg_vld  in  1  request valid.
- arg_rdy  out  1  request ready.
- arg_a  in  FLEN  dividend.
- arg_b  in  FLEN  divisor.
- div_a  out  FLEN  operand A to divider.
- div_b  out  FLEN  operand B to divider.
- div_up_valid  out  1  issue pulse to divider.
- div_res  in  FLEN  divider result.
- div_down_valid  in  1  divider result valid.
- div_busy  in  1  divider busy.
- div_error  in  1  divider error flag.
- res_vld  out  1  FIFO head valid.
- res_rdy  in  1  consumer ready.
- res  out  FLEN  FIFO head result.
- res_err  out  1  FIFO head error flag.
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; FIFO is emptied.
  - div_a, div_b, div_up_valid, res, res_err, res_vld and timeout all reset to 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - arg_rdy = (count < DEPTH) && !div_busy.
  - On arg_vld && arg_rdy: register arg_a/arg_b into div_a/div_b, go to ISSUE.
- ISSUE:
  - div_up_valid=1 for exactly this one cycle; then go to WAIT.
  - If div_down_valid is already asserted in this cycle, treat it as in WAIT: push and return to IDLE.
- WAIT:
  - div_up_valid=0; div_a/div_b held constant.
  - On div_down_valid: push {div_res, div_error} into FIFO, go to IDLE.
- arg_rdy is 0 in ISSUE and WAIT, so at most one operation is in flight.
- div_down_valid while IDLE is ignored; this covers stale results after reset.
- Capacity:
  - Requests are admitted only when count < DEPTH, so a push never overflows.
  - A full FIFO with res_rdy held low stalls intake (arg_rdy=0).
- FIFO:
  - res_vld = (count != 0).
  - Pop on res_vld && res_rdy.
  - res and res_err are driven from the head entry.
  - Simultaneous push and pop leaves count unchanged; data order is preserved.
  - Pointers wrap modulo DEPTH.
  - count is $clog2(DEPTH)+1 bits wide.
- Latency: request accept → div_up_valid next cycle → result visible at res one cycle after div_down_valid.
- Throughput: at most one request per (divider latency + 2) cycles.
- div_error is passed through unmodified. Inexact is not an error; the divider already masks it.

Optional Feature:
- Macro: F_DIV_ISSUER_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT.
  - If TIMEOUT cycles elapse without div_down_valid, push {FLEN canonical qNaN (64-bit: 0x7FF8000000000000), err=1}.
  - Set timeout=1 (sticky until reset) and return to IDLE.
  - A late div_down_valid arriving afterwards in IDLE is ignored.
- When undefined:
  - No counter is built; WAIT waits indefinitely.
  - timeout is tied to 0.

Test Plan:
- 6.0/2.0: arg_a=0x4018000000000000, arg_b=0x4000000000000000 → one div_up_valid pulse; operands stable until down_valid; res=0x4008000000000000, res_err=0.
- Divide by zero: 1.0/0.0 (0x3FF0000000000000 / 0) → res=0x7FF0000000000000, res_err=1.
- Back-pressure: res_rdy=0, issue 5 requests → 4 results buffered, arg_rdy stays 0 for the 5th. Then res_rdy=1 → results drain in order, 5th accepted, 5 results total.
- Simultaneous push/pop with count=DEPTH-1 → count remains DEPTH-1, no drop, no duplicate.
- Reset mid-WAIT: rst=0 for 1 cycle, then a stale div_down_valid arrives → res_vld stays 0, arg_rdy=1.
- With F_DIV_ISSUER_TIMEOUT_EN, TIMEOUT=16 and a divider model that never returns → after 16 WAIT cycles: res=0x7FF8000000000000, res_err=1, timeout=1.
